// File: rtl/aes_pkg.sv
// AES shared types and constants.
// Forward S-box table and block geometry used across the AES datapath.
package aes_pkg;

    typedef logic [7:0] byte_t;

    localparam int AES_BLOCK_BYTES = 16;

    // SBOX[x] is the forward substitution of byte x; entry 0 sits in the top bits.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box.
// Purely combinational byte substitution written as a 256-entry ROM case.
module aes_sbox
    import aes_pkg::*;
(
    input  byte_t data,
    output byte_t subed
);

    // Constant ROM lookup of the forward substitution.
    always_comb begin
        subed = 8'h00;
        case (data)
            8'h00: subed = 8'h63;
            8'h01: subed = 8'h7c;
            8'h02: subed = 8'h77;
            8'h03: subed = 8'h7b;
            8'h04: subed = 8'hf2;
            8'h05: subed = 8'h6b;
            8'h06: subed = 8'h6f;
            8'h07: subed = 8'hc5;
            8'h08: subed = 8'h30;
            8'h09: subed = 8'h01;
            8'h0a: subed = 8'h67;
            8'h0b: subed = 8'h2b;
            8'h0c: subed = 8'hfe;
            8'h0d: subed = 8'hd7;
            8'h0e: subed = 8'hab;
            8'h0f: subed = 8'h76;
            8'h10: subed = 8'hca;
            8'h11: subed = 8'h82;
            8'h12: subed = 8'hc9;
            8'h13: subed = 8'h7d;
            8'h14: subed = 8'hfa;
            8'h15: subed = 8'h59;
            8'h16: subed = 8'h47;
            8'h17: subed = 8'hf0;
            8'h18: subed = 8'had;
            8'h19: subed = 8'hd4;
            8'h1a: subed = 8'ha2;
            8'h1b: subed = 8'haf;
            8'h1c: subed = 8'h9c;
            8'h1d: subed = 8'ha4;
            8'h1e: subed = 8'h72;
            8'h1f: subed = 8'hc0;
            8'h20: subed = 8'hb7;
            8'h21: subed = 8'hfd;
            8'h22: subed = 8'h93;
            8'h23: subed = 8'h26;
            8'h24: subed = 8'h36;
            8'h25: subed = 8'h3f;
            8'h26: subed = 8'hf7;
            8'h27: subed = 8'hcc;
            8'h28: subed = 8'h34;
            8'h29: subed = 8'ha5;
            8'h2a: subed = 8'he5;
            8'h2b: subed = 8'hf1;
            8'h2c: subed = 8'h71;
            8'h2d: subed = 8'hd8;
            8'h2e: subed = 8'h31;
            8'h2f: subed = 8'h15;
            8'h30: subed = 8'h04;
            8'h31: subed = 8'hc7;
            8'h32: subed = 8'h23;
            8'h33: subed = 8'hc3;
            8'h34: subed = 8'h18;
            8'h35: subed = 8'h96;
            8'h36: subed = 8'h05;
            8'h37: subed = 8'h9a;
            8'h38: subed = 8'h07;
            8'h39: subed = 8'h12;
            8'h3a: subed = 8'h80;
            8'h3b: subed = 8'he2;
            8'h3c: subed = 8'heb;
            8'h3d: subed = 8'h27;
            8'h3e: subed = 8'hb2;
            8'h3f: subed = 8'h75;
            8'h40: subed = 8'h09;
            8'h41: subed = 8'h83;
            8'h42: subed = 8'h2c;
            8'h43: subed = 8'h1a;
            8'h44: subed = 8'h1b;
            8'h45: subed = 8'h6e;
            8'h46: subed = 8'h5a;
            8'h47: subed = 8'ha0;
            8'h48: subed = 8'h52;
            8'h49: subed = 8'h3b;
            8'h4a: subed = 8'hd6;
            8'h4b: subed = 8'hb3;
            8'h4c: subed = 8'h29;
            8'h4d: subed = 8'he3;
            8'h4e: subed = 8'h2f;
            8'h4f: subed = 8'h84;
            8'h50: subed = 8'h53;
            8'h51: subed = 8'hd1;
            8'h52: subed = 8'h00;
            8'h53: subed = 8'hed;
            8'h54: subed = 8'h20;
            8'h55: subed = 8'hfc;
            8'h56: subed = 8'hb1;
            8'h57: subed = 8'h5b;
            8'h58: subed = 8'h6a;
            8'h59: subed = 8'hcb;
            8'h5a: subed = 8'hbe;
            8'h5b: subed = 8'h39;
            8'h5c: subed = 8'h4a;
            8'h5d: subed = 8'h4c;
            8'h5e: subed = 8'h58;
            8'h5f: subed = 8'hcf;
            8'h60: subed = 8'hd0;
            8'h61: subed = 8'hef;
            8'h62: subed = 8'haa;
            8'h63: subed = 8'hfb;
            8'h64: subed = 8'h43;
            8'h65: subed = 8'h4d;
            8'h66: subed = 8'h33;
            8'h67: subed = 8'h85;
            8'h68: subed = 8'h45;
            8'h69: subed = 8'hf9;
            8'h6a: subed = 8'h02;
            8'h6b: subed = 8'h7f;
            8'h6c: subed = 8'h50;
            8'h6d: subed = 8'h3c;
            8'h6e: subed = 8'h9f;
            8'h6f: subed = 8'ha8;
            8'h70: subed = 8'h51;
            8'h71: subed = 8'ha3;
            8'h72: subed = 8'h40;
            8'h73: subed = 8'h8f;
            8'h74: subed = 8'h92;
            8'h75: subed = 8'h9d;
            8'h76: subed = 8'h38;
            8'h77: subed = 8'hf5;
            8'h78: subed = 8'hbc;
            8'h79: subed = 8'hb6;
            8'h7a: subed = 8'hda;
            8'h7b: subed = 8'h21;
            8'h7c: subed = 8'h10;
            8'h7d: subed = 8'hff;
            8'h7e: subed = 8'hf3;
            8'h7f: subed = 8'hd2;
            8'h80: subed = 8'hcd;
            8'h81: subed = 8'h0c;
            8'h82: subed = 8'h13;
            8'h83: subed = 8'hec;
            8'h84: subed = 8'h5f;
            8'h85: subed = 8'h97;
            8'h86: subed = 8'h44;
            8'h87: subed = 8'h17;
            8'h88: subed = 8'hc4;
            8'h89: subed = 8'ha7;
            8'h8a: subed = 8'h7e;
            8'h8b: subed = 8'h3d;
            8'h8c: subed = 8'h64;
            8'h8d: subed = 8'h5d;
            8'h8e: subed = 8'h19;
            8'h8f: subed = 8'h73;
            8'h90: subed = 8'h60;
            8'h91: subed = 8'h81;
            8'h92: subed = 8'h4f;
            8'h93: subed = 8'hdc;
            8'h94: subed = 8'h22;
            8'h95: subed = 8'h2a;
            8'h96: subed = 8'h90;
            8'h97: subed = 8'h88;
            8'h98: subed = 8'h46;
            8'h99: subed = 8'hee;
            8'h9a: subed = 8'hb8;
            8'h9b: subed = 8'h14;
            8'h9c: subed = 8'hde;
            8'h9d: subed = 8'h5e;
            8'h9e: subed = 8'h0b;
            8'h9f: subed = 8'hdb;
            8'ha0: subed = 8'he0;
            8'ha1: subed = 8'h32;
            8'ha2: subed = 8'h3a;
            8'ha3: subed = 8'h0a;
            8'ha4: subed = 8'h49;
            8'ha5: subed = 8'h06;
            8'ha6: subed = 8'h24;
            8'ha7: subed = 8'h5c;
            8'ha8: subed = 8'hc2;
            8'ha9: subed = 8'hd3;
            8'haa: subed = 8'hac;
            8'hab: subed = 8'h62;
            8'hac: subed = 8'h91;
            8'had: subed = 8'h95;
            8'hae: subed = 8'he4;
            8'haf: subed = 8'h79;
            8'hb0: subed = 8'he7;
            8'hb1: subed = 8'hc8;
            8'hb2: subed = 8'h37;
            8'hb3: subed = 8'h6d;
            8'hb4: subed = 8'h8d;
            8'hb5: subed = 8'hd5;
            8'hb6: subed = 8'h4e;
            8'hb7: subed = 8'ha9;
            8'hb8: subed = 8'h6c;
            8'hb9: subed = 8'h56;
            8'hba: subed = 8'hf4;
            8'hbb: subed = 8'hea;
            8'hbc: subed = 8'h65;
            8'hbd: subed = 8'h7a;
            8'hbe: subed = 8'hae;
            8'hbf: subed = 8'h08;
            8'hc0: subed = 8'hba;
            8'hc1: subed = 8'h78;
            8'hc2: subed = 8'h25;
            8'hc3: subed = 8'h2e;
            8'hc4: subed = 8'h1c;
            8'hc5: subed = 8'ha6;
            8'hc6: subed = 8'hb4;
            8'hc7: subed = 8'hc6;
            8'hc8: subed = 8'he8;
            8'hc9: subed = 8'hdd;
            8'hca: subed = 8'h74;
            8'hcb: subed = 8'h1f;
            8'hcc: subed = 8'h4b;
            8'hcd: subed = 8'hbd;
            8'hce: subed = 8'h8b;
            8'hcf: subed = 8'h8a;
            8'hd0: subed = 8'h70;
            8'hd1: subed = 8'h3e;
            8'hd2: subed = 8'hb5;
            8'hd3: subed = 8'h66;
            8'hd4: subed = 8'h48;
            8'hd5: subed = 8'h03;
            8'hd6: subed = 8'hf6;
            8'hd7: subed = 8'h0e;
            8'hd8: subed = 8'h61;
            8'hd9: subed = 8'h35;
            8'hda: subed = 8'h57;
            8'hdb: subed = 8'hb9;
            8'hdc: subed = 8'h86;
            8'hdd: subed = 8'hc1;
            8'hde: subed = 8'h1d;
            8'hdf: subed = 8'h9e;
            8'he0: subed = 8'he1;
            8'he1: subed = 8'hf8;
            8'he2: subed = 8'h98;
            8'he3: subed = 8'h11;
            8'he4: subed = 8'h69;
            8'he5: subed = 8'hd9;
            8'he6: subed = 8'h8e;
            8'he7: subed = 8'h94;
            8'he8: subed = 8'h9b;
            8'he9: subed = 8'h1e;
            8'hea: subed = 8'h87;
            8'heb: subed = 8'he9;
            8'hec: subed = 8'hce;
            8'hed: subed = 8'h55;
            8'hee: subed = 8'h28;
            8'hef: subed = 8'hdf;
            8'hf0: subed = 8'h8c;
            8'hf1: subed = 8'ha1;
            8'hf2: subed = 8'h89;
            8'hf3: subed = 8'h0d;
            8'hf4: subed = 8'hbf;
            8'hf5: subed = 8'he6;
            8'hf6: subed = 8'h42;
            8'hf7: subed = 8'h68;
            8'hf8: subed = 8'h41;
            8'hf9: subed = 8'h99;
            8'hfa: subed = 8'h2d;
            8'hfb: subed = 8'h0f;
            8'hfc: subed = 8'hb0;
            8'hfd: subed = 8'h54;
            8'hfe: subed = 8'hbb;
            8'hff: subed = 8'h16;
            default: subed = 8'h00;
        endcase
    end

endmodule

// File: rtl/sub_bytes.sv
// AES SubBytes stage.
// One S-box per byte lane followed by a single register stage.
module sub_bytes
    import aes_pkg::*;
#(
    parameter int size = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              v_i,
    input  logic [size*8-1:0] block,
    output logic              v_o,
    output logic [size*8-1:0] subed_block
);

    logic [size*8-1:0] subed_next;

    if (size < 1 || size > AES_BLOCK_BYTES) begin : g_bad_size
        $error("sub_bytes: size must be 1..16");
    end

    for (genvar k = 0; k < size; k++) begin : g_lane
        aes_sbox u_sbox (
            .data  (block[8*k +: 8]),
            .subed (subed_next[8*k +: 8])
        );
    end

    // Capture substituted lanes on valid; valid itself follows v_i.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_o         <= 1'b0;
            subed_block <= '0;
        end else begin
            v_o <= v_i;
            if (v_i) begin
                subed_block <= subed_next;
            end
        end
    end

endmodule

// File: tb/tb_sub_bytes.sv
// Self-checking bench for sub_bytes (size 16 and size 4 instances).
// Reference S-box is derived from GF(2^8) inversion plus the affine map.
module tb_sub_bytes;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         v_i;
    logic [127:0] block;
    logic         v_o;
    logic [127:0] subed_block;
    logic [31:0]  block4;
    logic         v_o4;
    logic [31:0]  subed_block4;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]   ref_tab [256];
    logic         ev;
    logic [127:0] eb;
    logic [31:0]  eb4;

    always #5 clk_i = ~clk_i;

    sub_bytes #(.size(16)) u_dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .v_i         (v_i),
        .block       (block),
        .v_o         (v_o),
        .subed_block (subed_block)
    );

    sub_bytes #(.size(4)) u_dut4 (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .v_i         (v_i),
        .block       (block4),
        .v_o         (v_o4),
        .subed_block (subed_block4)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox_math(input logic [7:0] b);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, b);
        if (b == 8'h00) inv = 8'h00;
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                   ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_ref(input logic [127:0] b);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = ref_tab[b[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive(input logic rst, input logic v,
                         input logic [127:0] b16, input logic [31:0] b4);
        logic [127:0] t4;
        reset_i = rst;
        v_i     = v;
        block   = b16;
        block4  = b4;
        @(posedge clk_i);
        #1;
        if (rst) begin
            ev  = 1'b0;
            eb  = '0;
            eb4 = '0;
        end else begin
            ev = v;
            if (v) begin
                eb  = sub_ref(b16);
                t4  = sub_ref({96'h0, b4});
                eb4 = t4[31:0];
            end
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, rnd128(), $urandom);
        drive(1'b1, 1'b1, rnd128(), $urandom);
        n_cmp++;
        if ({v_o, subed_block} !== 129'h0) begin
            n_err++;
            $display("FAIL reset16: got v=%b d=%h want v=0 d=0", v_o, subed_block);
        end
        n_cmp++;
        if ({v_o4, subed_block4} !== 33'h0) begin
            n_err++;
            $display("FAIL reset4: got v=%b d=%h want v=0 d=0", v_o4, subed_block4);
        end
    endtask

    task automatic test_vectors();
        logic [127:0] vin  [4];
        logic [127:0] vexp [4];
        vin[0]  = 128'h00102030405060708090a0b0c0d0e0f0;
        vexp[0] = 128'h63cab7040953d051cd60e0e7ba70e18c;
        vin[1]  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        vexp[1] = 128'hd42711aee0bf98f1b8b45de51e415230;
        vin[2]  = {16{8'h00}};
        vexp[2] = {16{8'h63}};
        vin[3]  = {16{8'hff}};
        vexp[3] = {16{8'h16}};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, vin[i], 32'h00ff1053);
            n_cmp++;
            if (v_o !== 1'b1 || subed_block !== vexp[i]) begin
                n_err++;
                $display("FAIL vector%0d: got v=%b d=%h want v=1 d=%h",
                         i, v_o, subed_block, vexp[i]);
            end
            n_cmp++;
            if (v_o4 !== 1'b1 || subed_block4 !== 32'h6316caed) begin
                n_err++;
                $display("FAIL vector4_%0d: got v=%b d=%h want v=1 d=6316caed",
                         i, v_o4, subed_block4);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, rnd128(), $urandom);
            n_cmp++;
            if (v_o !== 1'b1 || subed_block !== eb || subed_block4 !== eb4) begin
                n_err++;
                $display("FAIL b2b%0d: got %h/%h want %h/%h",
                         i, subed_block, subed_block4, eb, eb4);
            end
        end
    endtask

    task automatic test_hold();
        logic [127:0] keep;
        drive(1'b0, 1'b1, rnd128(), $urandom);
        keep = eb;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, rnd128(), $urandom);
            n_cmp++;
            if (v_o !== 1'b0 || subed_block !== keep || subed_block4 !== eb4) begin
                n_err++;
                $display("FAIL hold%0d: got v=%b d=%h want v=0 d=%h",
                         i, v_o, subed_block, keep);
            end
        end
    endtask

    task automatic test_random();
        logic v;
        for (int i = 0; i < 300; i++) begin
            v = 1'($urandom_range(0, 1));
            drive(1'b0, v, rnd128(), $urandom);
            n_cmp++;
            if ({v_o, subed_block, v_o4, subed_block4} !== {ev, eb, ev, eb4}) begin
                n_err++;
                $display("FAIL random%0d: got v=%b d=%h d4=%h want v=%b d=%h d4=%h",
                         i, v_o, subed_block, subed_block4, ev, eb, eb4);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] b;
        drive(1'b0, 1'b1, rnd128(), $urandom);
        drive(1'b1, 1'b1, rnd128(), $urandom);
        n_cmp++;
        if ({v_o, subed_block, v_o4, subed_block4} !== 162'h0) begin
            n_err++;
            $display("FAIL midreset: got v=%b d=%h want v=0 d=0", v_o, subed_block);
        end
        drive(1'b0, 1'b0, rnd128(), $urandom);
        n_cmp++;
        if (v_o !== 1'b0 || subed_block !== 128'h0) begin
            n_err++;
            $display("FAIL postreset_idle: got v=%b d=%h want v=0 d=0", v_o, subed_block);
        end
        b = rnd128();
        drive(1'b0, 1'b1, b, b[31:0]);
        n_cmp++;
        if (v_o !== 1'b1 || subed_block !== sub_ref(b)) begin
            n_err++;
            $display("FAIL postreset_first: got v=%b d=%h want v=1 d=%h",
                     v_o, subed_block, sub_ref(b));
        end
    endtask

    task automatic test_exhaustive();
        logic [127:0] b16;
        logic [31:0]  b4;
        logic [7:0]   bv;
        for (int k = 0; k < 16; k++) begin
            for (int b = 0; b < 256; b++) begin
                bv  = 8'(b);
                b16 = rnd128();
                b4  = $urandom;
                b16[8*k +: 8]     = bv;
                b4[8*(k%4) +: 8]  = bv;
                drive(1'b0, 1'b1, b16, b4);
                n_cmp++;
                if (subed_block[8*k +: 8] !== ref_tab[b]
                    || subed_block4[8*(k%4) +: 8] !== ref_tab[b]
                    || subed_block !== eb || subed_block4 !== eb4) begin
                    n_err++;
                    $display("FAIL exh lane%0d byte%02h: got %h/%h want %h/%h",
                             k, bv, subed_block, subed_block4, eb, eb4);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_tab[i] = sbox_math(8'(i));
        reset_i = 1'b1;
        v_i     = 1'b0;
        block   = '0;
        block4  = '0;
        ev      = 1'b0;
        eb      = '0;
        eb4     = '0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_hold();
        test_random();
        test_reset_mid();
        test_exhaustive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
